instruction_fetch_unit: RTL and testbench

//  Requester side of the instruction-memory read interface: owns the PC, drives Mem_Addr into

---
 rtl/instruction_fetch_unit.sv | 83 ++++++++
 tb/tb_instruction_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch requester: owns the PC, issues one-cycle-latency memory reads and
// buffers (PC, Inst) pairs in a small FIFO toward decode, with redirect-driven flush.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic [31:0] Mem_Addr,
  input  logic [31:0] Mem_Inst,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [31:0] Out_Inst,
  output logic [31:0] Out_PC,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0]   r_pc;
  logic [31:0]   r_req_pc;
  logic          r_inflight;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]   r_fifo_inst [FIFO_DEPTH];

  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [CW:0]   w_need;

  assign Out_Valid = (r_count != '0);
  assign Out_PC    = Out_Valid ? r_fifo_pc[r_rd_ptr]   : 32'h0;
  assign Out_Inst  = Out_Valid ? r_fifo_inst[r_rd_ptr] : 32'h0;
  assign Mem_Addr  = r_pc;

  assign w_pop  = Out_Valid & Out_Ready;
  assign w_push = r_inflight;

  // Slots already spoken for after this edge; a new request needs one more free slot.
  assign w_need  = {1'b0, r_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
  assign w_issue = (w_need < (CW+1)'(FIFO_DEPTH));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (Redirect) begin
      r_pc       <= Redirect_PC & ~32'h3;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_pc <= r_pc + 32'd4;
      if (w_push)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Redirect && w_issue) r_req_pc <= r_pc;
    if (!Redirect && w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_req_pc;
      r_fifo_inst[r_wr_ptr] <= Mem_Inst;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst_n && !Redirect && w_push && !w_pop)
      assert (r_count < CW'(FIFO_DEPTH));
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: stimulus queues expected PCs, a negedge
// monitor pops and compares every accepted (PC, Inst) pair and checks stall stability.
module tb_instruction_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        Clk = 1'b0;
  logic        Rst_n, Out_Ready, Redirect;
  logic [31:0] Redirect_PC, Mem_Addr, Mem_Inst, Out_Inst, Out_PC;
  logic        Out_Valid;

  logic        rst5_n;
  logic [31:0] mem_addr5, mem_inst5, out_inst5, out_pc5;
  logic        out_valid5;

  always #5 Clk = ~Clk;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Mem_Addr(Mem_Addr), .Mem_Inst(Mem_Inst),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Inst(Out_Inst), .Out_PC(Out_PC),
    .Redirect(Redirect), .Redirect_PC(Redirect_PC)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut5 (
    .Clk(Clk), .Rst_n(rst5_n), .Mem_Addr(mem_addr5), .Mem_Inst(mem_inst5),
    .Out_Valid(out_valid5), .Out_Ready(1'b1), .Out_Inst(out_inst5), .Out_PC(out_pc5),
    .Redirect(1'b0), .Redirect_PC(32'h0)
  );

  always @(posedge Clk) begin
    Mem_Inst  <= Mem_Addr ^ K;
    mem_inst5 <= mem_addr5 ^ K;
  end

  logic [31:0] exp_q[$];
  logic [31:0] q_tail;
  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic top_up();
    while (exp_q.size() < 16) begin
      exp_q.push_back(q_tail);
      q_tail = q_tail + 32'd4;
    end
  endtask

  task automatic push_seq(input logic [31:0] start);
    exp_q.delete();
    q_tail = start;
    top_up();
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    top_up();
  endtask

  task automatic expect_redirect_timing(input string nm, input logic [31:0] tgt);
    @(negedge Clk); #1; check({nm, "_vld_e1"}, 32'(Out_Valid), 32'd0);
    @(negedge Clk); #1; check({nm, "_vld_e2"}, 32'(Out_Valid), 32'd0);
    @(negedge Clk); #1; check({nm, "_vld_e3"}, 32'(Out_Valid), 32'd1);
    check({nm, "_pc"}, Out_PC, tgt);
    @(posedge Clk); #1;
  endtask

  // Monitor: compare accepted entries against the queue, and held outputs across stalls.
  initial begin
    logic        hold_vld;
    logic [31:0] hold_pc, hold_inst, e;
    hold_vld = 1'b0;
    hold_pc = '0;
    hold_inst = '0;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        hold_vld = 1'b0;
      end else begin
        if (hold_vld) begin
          check("hold_vld", 32'(Out_Valid), 32'd1);
          check("hold_pc", Out_PC, hold_pc);
          check("hold_inst", Out_Inst, hold_inst);
        end
        if (Out_Valid && Out_Ready && !Redirect) begin
          n_pops++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_underflow: got pc %h expected none queued", Out_PC);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc", Out_PC, e);
            check("sb_inst", Out_Inst, e ^ K);
          end
        end
        hold_vld  = Out_Valid && !Out_Ready && !Redirect;
        hold_pc   = Out_PC;
        hold_inst = Out_Inst;
      end
    end
  end

  initial begin
    int p0, k;
    logic [31:0] exp5 [4];
    exp5[0] = 32'hFFFF_FFF8; exp5[1] = 32'hFFFF_FFFC;
    exp5[2] = 32'h0000_0000; exp5[3] = 32'h0000_0004;
    Rst_n = 1'b0; rst5_n = 1'b0; Out_Ready = 1'b0; Redirect = 1'b0; Redirect_PC = '0;
    q_tail = '0;
    repeat (3) step();
    check("rst_vld", 32'(Out_Valid), 32'd0);
    check("rst_addr", Mem_Addr, 32'h0);
    check("rst_pc", Out_PC, 32'h0);
    check("rst_inst", Out_Inst, 32'h0);

    // Streaming with decode always ready
    Out_Ready = 1'b1;
    push_seq(32'h0);
    Rst_n = 1'b1;
    p0 = n_pops;
    repeat (10) @(posedge Clk);
    @(negedge Clk); #1;
    check("t1_pops", 32'(n_pops - p0), 32'd9);
    @(posedge Clk); #1;

    // Back-pressure from the start
    Rst_n = 1'b0; Out_Ready = 1'b0;
    step();
    push_seq(32'h0);
    Rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      check("t2_addr", Mem_Addr, (i == 1) ? 32'h4 : 32'h8);
      if (i >= 2) begin
        check("t2_vld", 32'(Out_Valid), 32'd1);
        check("t2_pc", Out_PC, 32'h0);
      end
    end
    Out_Ready = 1'b1;
    repeat (12) step();

    // Mid-stream redirect
    Redirect = 1'b1; Redirect_PC = 32'h40;
    push_seq(32'h40);
    step();
    Redirect = 1'b0;
    expect_redirect_timing("t3", 32'h40);
    repeat (6) step();

    // Unaligned target, redirect colliding with a pop from a full FIFO
    Out_Ready = 1'b0;
    repeat (4) step();
    check("t4_full_vld", 32'(Out_Valid), 32'd1);
    Out_Ready = 1'b1; Redirect = 1'b1; Redirect_PC = 32'h43;
    push_seq(32'h40);
    step();
    Redirect = 1'b0;
    expect_redirect_timing("t4", 32'h40);
    repeat (6) step();

    // Asynchronous reset mid-cycle, then random traffic
    #2;
    Rst_n = 1'b0;
    #1;
    check("t6_rst_vld", 32'(Out_Valid), 32'd0);
    check("t6_rst_addr", Mem_Addr, 32'h0);
    check("t6_rst_pc", Out_PC, 32'h0);
    check("t6_rst_inst", Out_Inst, 32'h0);
    step();
    step();
    push_seq(32'h0);
    Rst_n = 1'b1;
    p0 = n_pops;
    for (int i = 0; i < 5000; i++) begin
      step();
      Out_Ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        Redirect = 1'b1;
        Redirect_PC = $urandom;
        push_seq(Redirect_PC & ~32'h3);
      end else begin
        Redirect = 1'b0;
      end
    end
    Redirect = 1'b0;
    step();
    check("t6_progress", 32'(n_pops - p0 > 2000), 32'd1);

    // Address wrap from a high reset PC
    check("t5_rst_addr", mem_addr5, 32'hFFFF_FFF8);
    step();
    rst5_n = 1'b1;
    k = 0;
    for (int c = 0; c < 10 && k < 4; c++) begin
      @(negedge Clk);
      if (out_valid5) begin
        check("t5_pc", out_pc5, exp5[k]);
        check("t5_inst", out_inst5, exp5[k] ^ K);
        k++;
      end
    end
    check("t5_count", 32'(k), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
